pipeline_trace_buffer: RTL
==========================

Name: pipeline_trace_buffer

Overview:
Synthesizable retirement-trace capture block for the RV32I pipeline. It records write-back events (pc, rd, data) into a circular buffer. Capture is armed by software or the bench, stops POST_TRIG events after a PC-match trigger, and is then read out through a 1-cycle-latency port. It sits beside the MEM/WB register. It replaces per-cycle console dumps with a bounded, on-chip history usable on hardware.

Parameters:
XLEN, 32, width of pc and data fields
DEPTH, 16, buffer entries; power of two, >= 2
POST_TRIG, 8, events captured after the trigger event; 0 <= POST_TRIG <= DEPTH-1
IDX_W, $clog2(DEPTH), index width (derived)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  capture gate; events ignored when 0
wb_valid  in  1  retirement event this cycle (MEM/WB reg_wr or store)
wb_pc  in  XLEN  pc of retiring instruction
wb_rd  in  5  destination register (0 for stores)
wb_data  in  XLEN  write-back value, or store data
arm  in  1  single-cycle pulse; clears buffer and starts capture
trig_en  in  1  enables PC-match trigger
trig_pc  in  XLEN  trigger PC
rd_req  in  1  read request
rd_idx  in  IDX_W  entry offset from oldest valid entry
rd_valid  out  1  read response valid, 1 cycle after rd_req
rd_hit  out  1  requested index < count
rd_pc  out  XLEN  entry pc
rd_rdst  out  5  entry rd
rd_data  out  XLEN  entry data
state  out  2  00 IDLE, 01 ARMED, 10 POST, 11 DONE
count  out  IDX_W+1  valid entries, saturates at DEPTH
trig_pos  out  IDX_W  offset-from-oldest of trigger entry; valid in DONE
done  out  1  state == DONE

Behaviour:
- Reset (async, any state or mid-capture): state=IDLE; wr_ptr, count, post_cnt, trig_pos=0; rd_valid, rd_hit, rd_pc, rd_rdst, rd_data=0; done=0. Buffer contents are not cleared.
- Event: ev = enable & wb_valid & (state==ARMED | state==POST).
- Write: on ev, entry[wr_ptr] <= {wb_pc, wb_rd, wb_data}; wr_ptr <= wr_ptr+1 mod DEPTH; count <= min(count+1, DEPTH). Once full, the oldest entry is overwritten.
- FSM, registered, one transition per cycle:
  IDLE --arm--> ARMED. wr_ptr, count, post_cnt clear in the same edge.
  ARMED --ev & trig_en & wb_pc==trig_pc--> POST, or DONE if POST_TRIG==0. The trigger event itself is written.
  ARMED with trig_en=0: free-running circular capture, no exit except arm or rst.
  POST: each ev increments post_cnt. The ev that makes post_cnt==POST_TRIG is written, then state -> DONE.
  DONE: no writes. arm -> ARMED (restart).
  arm in ARMED or POST: restart capture (clear, stay or return to ARMED). arm takes priority over a same-cycle trigger or event; that event is discarded.
- trig_pos: latched on DONE entry as count_at_done-1-POST_TRIG, computed at IDX_W+1 width.
- Read: usable in any state. Physical address = (wr_ptr - count + rd_idx) mod DEPTH, using the current cycle's wr_ptr and count.
  On rd_req, the next cycle gives rd_valid=1 and rd_hit=(rd_idx<count). Data fields show the entry if hit, else 0.
  Without rd_req, the next cycle gives rd_valid=0 and the data fields hold their last values.
- Read/write same slot, same cycle: read returns the pre-write contents.
- Wrap: count==DEPTH means the oldest entry is at wr_ptr. All index math is mod DEPTH. No ptr/count overflow.
- wb_valid while IDLE or DONE: ignored, no state change.

Test Plan:
- Reset: assert rst mid-POST at a non-edge time -> state=00, count=0, done=0 immediately. After release, rd_req idx 0 gives rd_valid=1, rd_hit=0, data 0.
- Basic trigger (DEPTH=16, POST_TRIG=8): arm, retire pcs 0x00,0x04,...,0x3C with trig_pc=0x20 -> DONE after pc 0x40 is written. count=9+... check: 17 events would saturate; with only pcs 0x00..0x40 retired, count=16, oldest pc=0x04, trig_pos=7, read idx 7 gives pc 0x20.
- Wrap/overwrite: trig_en=0, 40 events pc=4*i -> state stays ARMED, count=16. idx0 gives pc 0x60 and idx15 gives pc 0x9C, matching the newest.
- POST_TRIG=0 variant: trigger on the 3rd event (pc 0x08) -> DONE the next cycle, count=3, trig_pos=2. Further wb_valid events leave count=3.
- Gating/priority: enable=0 events are not captured. arm on the same cycle as the trigger PC -> state ARMED, count=0, no trigger.
- Read-during-write: read the slot being overwritten in ARMED with a full buffer -> returns the old entry. The next read of the same idx returns the new entry.

Source files
------------

// File: rtl/pipeline_trace_buffer_if.sv
// Retirement-event and trace-readout signals of the pipeline trace buffer.
// The pipeline/bench side uses the master modport, the buffer uses slave.
interface pipeline_trace_buffer_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4
);
    logic             wb_valid;
    logic [XLEN-1:0]  wb_pc;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             rd_req;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic             rd_hit;
    logic [XLEN-1:0]  rd_pc;
    logic [4:0]       rd_rdst;
    logic [XLEN-1:0]  rd_data;

    modport master (
        output wb_valid, wb_pc, wb_rd, wb_data, rd_req, rd_idx,
        input  rd_valid, rd_hit, rd_pc, rd_rdst, rd_data
    );

    modport slave (
        input  wb_valid, wb_pc, wb_rd, wb_data, rd_req, rd_idx,
        output rd_valid, rd_hit, rd_pc, rd_rdst, rd_data
    );
endinterface

// File: rtl/pipeline_trace_buffer.sv
// Circular retirement-trace buffer: records (pc, rd, data) write-back events
// while armed, stops POST_TRIG events after a PC-match trigger, and is read
// back relative to the oldest valid entry with one cycle of latency.
module pipeline_trace_buffer #(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_trace_buffer_if.slave  bus,
    input  logic                    enable,
    input  logic                    arm,
    input  logic                    trig_en,
    input  logic [XLEN-1:0]         trig_pc,
    output logic [1:0]              state,
    output logic [IDX_W:0]          count,
    output logic [IDX_W-1:0]        trig_pos,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0] POST_C  = (IDX_W+1)'(POST_TRIG);
    localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]   count_q, count_d, count_inc;
    logic [IDX_W:0]   post_cnt_q, post_cnt_d;
    logic [IDX_W-1:0] trig_pos_q, trig_pos_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_hit_q, rd_hit_d;
    entry_t           rd_ent_q, rd_ent_d;
    entry_t           mem_q [DEPTH];
    logic             we;
    logic             trig_hit;
    logic [IDX_W-1:0] rd_addr;

    // Capture control: arm wins over any same-cycle event; count saturates
    // at DEPTH so a full buffer keeps overwriting its oldest entry.
    always_comb begin
        we         = enable & bus.wb_valid & ((state_q == ARMED) | (state_q == POST)) & ~arm;
        trig_hit   = trig_en & (bus.wb_pc == trig_pc);
        count_inc  = (count_q == DEPTH_C) ? count_q : count_q + 1'b1;
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        post_cnt_d = post_cnt_q;
        trig_pos_d = trig_pos_q;
        if (arm) begin
            state_d    = ARMED;
            wr_ptr_d   = '0;
            count_d    = '0;
            post_cnt_d = '0;
        end else if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_inc;
            if (state_q == ARMED && trig_hit) begin
                post_cnt_d = '0;
                if (POST_TRIG == 0) begin
                    state_d    = DONE;
                    trig_pos_d = IDX_W'(count_inc - ONE_C - POST_C);
                end else begin
                    state_d = POST;
                end
            end else if (state_q == POST) begin
                post_cnt_d = post_cnt_q + 1'b1;
                if (post_cnt_d == POST_C) begin
                    state_d    = DONE;
                    trig_pos_d = IDX_W'(count_inc - ONE_C - POST_C);
                end
            end
        end
    end

    // Read port: index is relative to the oldest entry; memory is read
    // before this edge's write lands, so a same-slot read sees old data.
    always_comb begin
        rd_addr    = wr_ptr_q - count_q[IDX_W-1:0] + bus.rd_idx;
        rd_valid_d = bus.rd_req;
        rd_hit_d   = rd_hit_q;
        rd_ent_d   = rd_ent_q;
        if (bus.rd_req) begin
            rd_hit_d = ({1'b0, bus.rd_idx} < count_q);
            rd_ent_d = rd_hit_d ? mem_q[rd_addr] : '0;
        end
    end

    // Control and read-response registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            post_cnt_q <= '0;
            trig_pos_q <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_ent_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            post_cnt_q <= post_cnt_d;
            trig_pos_q <= trig_pos_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_ent_q   <= rd_ent_d;
        end
    end

    // Trace storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q] <= '{pc: bus.wb_pc, rd: bus.wb_rd, data: bus.wb_data};
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_hit   = rd_hit_q;
    assign bus.rd_pc    = rd_ent_q.pc;
    assign bus.rd_rdst  = rd_ent_q.rd;
    assign bus.rd_data  = rd_ent_q.data;
    assign state        = state_q;
    assign count        = count_q;
    assign trig_pos     = trig_pos_q;
    assign done         = (state_q == DONE);
endmodule
